exp_align_unit: RTL and testbench

EXP_ALIGN_UNIT -- requirements
Module: exp_align_unit

---
 rtl/exp_align_unit.sv | 114 +++++++++++
 tb/tb_exp_align_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp_align_unit.sv
// Aligns the smaller-magnitude floating-point operand's mantissa to the larger exponent.
// Build option ALIGN_STICKY_EN: shifted-out bits are ORed into MANT_MIN[0] as a sticky bit.
module exp_align_unit #(
  parameter  int unsigned EW = 8,
  parameter  int unsigned SW = 23,
  localparam int unsigned W  = 1 + EW + SW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [W-1:0]  DATA_X,
  input  logic [W-1:0]  DATA_Y,
  output logic          BUSY,
  output logic          DONE,
  output logic          SWAP,
  output logic          SIGN_MAX,
  output logic          SIGN_MIN,
  output logic [EW-1:0] EXP_OUT,
  output logic [SW+3:0] MANT_MAX,
  output logic [SW+3:0] MANT_MIN
);

  localparam int unsigned MW = SW + 4;
  localparam int unsigned CW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, shift_en, finish;

  logic [EW-1:0] ex, ey, e_hi, e_lo, e_diff;
  logic [SW-1:0] mx, my;
  logic          x_big;
  logic [CW-1:0] shift_n;
  logic [MW-1:0] fx, fy, mant_shr;

  // Operand decode and ordering for the capture edge
  always_comb begin
    ex     = DATA_X[W-2 -: EW];
    ey     = DATA_Y[W-2 -: EW];
    mx     = DATA_X[SW-1:0];
    my     = DATA_Y[SW-1:0];
    x_big  = (ex > ey) || ((ex == ey) && (mx >= my));
    e_hi   = x_big ? ex : ey;
    e_lo   = x_big ? ey : ex;
    e_diff = e_hi - e_lo;
    if (32'(e_diff) > MW) shift_n = CW'(MW);
    else                  shift_n = CW'(e_diff);
    fx     = {|ex, mx, 3'b000};
    fy     = {|ey, my, 3'b000};
  end

  always_comb begin
    mant_shr = MANT_MIN >> 1;
`ifdef ALIGN_STICKY_EN
    mant_shr[0] = MANT_MIN[1] | MANT_MIN[0];
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Every operation passes through SHIFT, even with a zero count, so that
  // DONE lands exactly 2+n edges after the accepting edge.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (START) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && START;
    shift_en = (state == SHIFT) && (cnt != '0);
    finish   = (state == FINISH);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SWAP     <= 1'b0;
      SIGN_MAX <= 1'b0;
      SIGN_MIN <= 1'b0;
      EXP_OUT  <= '0;
      MANT_MAX <= '0;
      MANT_MIN <= '0;
    end else begin
      DONE <= finish;
      if (finish) BUSY <= 1'b0;
      if (accept) begin
        BUSY     <= 1'b1;
        SWAP     <= ~x_big;
        SIGN_MAX <= x_big ? DATA_X[W-1] : DATA_Y[W-1];
        SIGN_MIN <= x_big ? DATA_Y[W-1] : DATA_X[W-1];
        EXP_OUT  <= e_hi;
        MANT_MAX <= x_big ? fx : fy;
        MANT_MIN <= x_big ? fy : fx;
        cnt      <= shift_n;
      end else if (shift_en) begin
        MANT_MIN <= mant_shr;
        cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exp_align_unit.sv
// Directed and randomized bench for exp_align_unit with a queue scoreboard of expected results.
module tb_exp_align_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DATA_X = '0;
  logic [31:0] DATA_Y = '0;
  logic        BUSY, DONE, SWAP, SIGN_MAX, SIGN_MIN;
  logic [7:0]  EXP_OUT;
  logic [26:0] MANT_MAX, MANT_MIN;

`ifdef ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic        swap, smax, smin;
    logic [7:0]  e;
    logic [26:0] mmax, mmin;
    int unsigned done_at;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  exp_align_unit #(.EW(8), .SW(23)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DATA_X(DATA_X), .DATA_Y(DATA_Y),
    .BUSY(BUSY), .DONE(DONE), .SWAP(SWAP), .SIGN_MAX(SIGN_MAX), .SIGN_MIN(SIGN_MIN),
    .EXP_OUT(EXP_OUT), .MANT_MAX(MANT_MAX), .MANT_MIN(MANT_MIN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic sw, smx, smn, input logic [7:0] e,
                              input logic [26:0] mmx, mmn, input int unsigned at);
    exp_t r;
    r.swap = sw; r.smax = smx; r.smin = smn; r.e = e;
    r.mmax = mmx; r.mmin = mmn; r.done_at = at;
    return r;
  endfunction

  // Reference: magnitude order on the 31-bit {exp,mant} field, integer mantissa shift
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int unsigned k);
    exp_t        r;
    logic [31:0] big, sml;
    logic [63:0] mb, ms, res;
    int unsigned d, n;
    if (y[30:0] > x[30:0]) begin big = y; sml = x; r.swap = 1'b1; end
    else                   begin big = x; sml = y; r.swap = 1'b0; end
    r.smax = big[31];
    r.smin = sml[31];
    r.e    = big[30:23];
    mb = (((big[30:23] != 0) ? 64'h800000 : 64'h0) + 64'(big[22:0])) * 8;
    ms = (((sml[30:23] != 0) ? 64'h800000 : 64'h0) + 64'(sml[22:0])) * 8;
    d  = int'(big[30:23]) - int'(sml[30:23]);
    n  = (d > 27) ? 27 : d;
    res = ms >> n;
    if (STICKY && ((ms & ((64'd2 << n) - 1)) != 0)) res = res | 64'd1;
    r.mmax    = mb[26:0];
    r.mmin    = res[26:0];
    r.done_at = k + 2 + n;
    return r;
  endfunction

  task automatic pulse_start(input logic [31:0] x, input logic [31:0] y, output int unsigned k);
    @(negedge CLK);
    DATA_X = x; DATA_Y = y; START = 1'b1;
    @(posedge CLK);
    #1;
    k = cyc;
    START = 1'b0;
    DATA_X = $urandom;
    DATA_Y = $urandom;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":busy"}, 64'(BUSY), 0);
    chk({tag, ":done"}, 64'(DONE), 0);
    chk({tag, ":swap"}, 64'(SWAP), 0);
    chk({tag, ":smax"}, 64'(SIGN_MAX), 0);
    chk({tag, ":smin"}, 64'(SIGN_MIN), 0);
    chk({tag, ":exp"},  64'(EXP_OUT), 0);
    chk({tag, ":mmax"}, 64'(MANT_MAX), 0);
    chk({tag, ":mmin"}, 64'(MANT_MIN), 0);
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, ":swap"}, 64'(SWAP), 64'(e.swap));
    chk({tag, ":smax"}, 64'(SIGN_MAX), 64'(e.smax));
    chk({tag, ":smin"}, 64'(SIGN_MIN), 64'(e.smin));
    chk({tag, ":exp"},  64'(EXP_OUT), 64'(e.e));
    chk({tag, ":mmax"}, 64'(MANT_MAX), 64'(e.mmax));
    chk({tag, ":mmin"}, 64'(MANT_MIN), 64'(e.mmin));
  endtask

  task automatic wait_done(input string tag, input bit hold);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin got = 1'b1; break; end
    end
    chk({tag, ":done_seen"}, 64'(got), 1);
    if (!got) return;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s:scoreboard observed=DONE expected=no_pending_op", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ":latency"}, 64'(cyc), 64'(e.done_at));
    chk({tag, ":busy_at_done"}, 64'(BUSY), 0);
    chk_res(tag, e);
    @(negedge CLK);
    chk({tag, ":done_pulse"}, 64'(DONE), 0);
    if (hold) begin
      repeat (2) @(negedge CLK);
      chk_res({tag, ":hold"}, e);
    end
  endtask

  initial begin
    int unsigned k;
    int          extra;
    logic [31:0] rx, ry;

    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b1;

    pulse_start(32'h40000000, 32'h3F800000, k);
    sb.push_back(mk(0, 0, 0, 8'h80, 27'h4000000, 27'h2000000, k + 3));
    wait_done("v_2_1", 1'b1);

    pulse_start(32'h3F800000, 32'hC0400000, k);
    sb.push_back(mk(1, 1, 0, 8'h80, 27'h6000000, 27'h2000000, k + 3));
    wait_done("v_1_m3", 1'b1);

    pulse_start(32'h3FC00000, 32'h3FC00000, k);
    sb.push_back(mk(0, 0, 0, 8'h7F, 27'h6000000, 27'h6000000, k + 2));
    wait_done("v_equal", 1'b1);

    pulse_start(32'h3F800000, 32'h3FC00000, k);
    sb.push_back(mk(1, 0, 0, 8'h7F, 27'h6000000, 27'h4000000, k + 2));
    wait_done("v_eqexp", 1'b0);

    pulse_start(32'h7F000000, 32'h00000001, k);
    sb.push_back(mk(0, 0, 0, 8'hFE, 27'h4000000, STICKY ? 27'h1 : 27'h0, k + 29));
    wait_done("v_d254", 1'b1);

    pulse_start(32'h4D000000, 32'h3F800001, k);
    sb.push_back(model(32'h4D000000, 32'h3F800001, k));
    wait_done("v_d27", 1'b0);

    pulse_start(32'h3F800000, 32'h4D800000, k);
    sb.push_back(model(32'h3F800000, 32'h4D800000, k));
    wait_done("v_d28", 1'b0);

    // START pulsed mid-shift must be ignored
    pulse_start(32'h7F000000, 32'h00000001, k);
    sb.push_back(mk(0, 0, 0, 8'hFE, 27'h4000000, STICKY ? 27'h1 : 27'h0, k + 29));
    repeat (5) @(negedge CLK);
    chk("busy_mid_shift", 64'(BUSY), 1);
    DATA_X = 32'h3F800000; DATA_Y = 32'hC0400000; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("ignore_start", 1'b0);
    extra = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    chk("no_extra_done", 64'(extra), 0);

    // START held high: second operation accepted on the edge after DONE
    @(negedge CLK);
    DATA_X = 32'h40000000; DATA_Y = 32'h3F800000; START = 1'b1;
    @(posedge CLK);
    #1;
    k = cyc;
    DATA_X = 32'h3F800000; DATA_Y = 32'hC0400000;
    sb.push_back(mk(0, 0, 0, 8'h80, 27'h4000000, 27'h2000000, k + 3));
    sb.push_back(mk(1, 1, 0, 8'h80, 27'h6000000, 27'h2000000, k + 7));
    wait_done("held_first", 1'b0);
    START = 1'b0;
    wait_done("held_second", 1'b1);

    // Reset during a long shift
    pulse_start(32'h7F000000, 32'h00000001, k);
    sb.push_back(model(32'h7F000000, 32'h00000001, k));
    repeat (6) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk_zero("rst_mid");
    void'(sb.pop_front());
    extra = 0;
    repeat (35) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    chk("rst_no_done", 64'(extra), 0);
    RST = 1'b1;
    pulse_start(32'h7F000000, 32'h00000001, k);
    sb.push_back(model(32'h7F000000, 32'h00000001, k));
    wait_done("after_rst", 1'b0);

    for (int i = 0; i < 8; i++) begin
      rx = $urandom;
      ry = $urandom;
      ry[30:23] = rx[30:23] ^ 8'($urandom_range(0, 31));
      pulse_start(rx, ry, k);
      sb.push_back(model(rx, ry, k));
      wait_done($sformatf("rnd%0d", i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
